// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: FSM state encoding,
// instruction access-fault codes and the default reset vectors.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_BUS_ERR  = 2'd1;
  localparam logic [1:0] FC_DEC_ERR  = 2'd2;
  localparam logic [1:0] FC_MISALIGN = 2'd3;

  localparam logic [31:0] NPC_RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] SOC_RESET_VEC = 32'h3000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: trap > access fault > redirect > fire.
// Also flags fault entry (or a fault-record update) and a trap exit from FAULT.
// Optional build macro PC_MISALIGN_CHECK_EN turns misaligned targets into faults.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INST_BYTES = 4,
  parameter int FAULT_W    = 2
) (
  input  state_e             state_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               out_valid_i,
  input  logic               out_ready_i,
  input  logic               redirect_valid_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  input  logic               trap_valid_i,
  input  logic [XLEN-1:0]    trap_pc_i,
  input  logic [FAULT_W-1:0] access_fault_i,
  output logic [XLEN-1:0]    pc_d_o,
  output logic               fault_set_o,
  output logic [XLEN-1:0]    fault_pc_d_o,
  output logic [FAULT_W-1:0] fault_cause_d_o,
  output logic               trap_exit_o
);

  // Targets are word-aligned by dropping the two low bits.
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] redir_tgt;
  logic            fire;

  assign trap_tgt  = {trap_pc_i[XLEN-1:2], 2'b00};
  assign redir_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign fire      = out_valid_i & out_ready_i;

  // Low target bits only matter when the misalignment check is built in.
  logic unused_low_bits;
  assign unused_low_bits = ^{trap_pc_i[1:0], redirect_pc_i[1:0]};

  // Priority selection of the next fetch address and fault bookkeeping.
  always_comb begin
    pc_d_o          = pc_i;
    fault_set_o     = 1'b0;
    fault_pc_d_o    = pc_i;
    fault_cause_d_o = access_fault_i;
    trap_exit_o     = 1'b0;
    unique case (state_i)
      RUN: begin
        if (trap_valid_i) begin
`ifdef PC_MISALIGN_CHECK_EN
          if (trap_pc_i[1:0] != 2'b00) begin
            fault_set_o     = 1'b1;
            fault_pc_d_o    = trap_pc_i;
            fault_cause_d_o = {FAULT_W{1'b1}};
          end else begin
            pc_d_o = trap_tgt;
          end
`else
          pc_d_o = trap_tgt;
`endif
        end else if (out_valid_i && (access_fault_i != FAULT_W'(FC_NONE))) begin
          fault_set_o = 1'b1;
        end else if (redirect_valid_i) begin
`ifdef PC_MISALIGN_CHECK_EN
          if (redirect_pc_i[1:0] != 2'b00) begin
            fault_set_o     = 1'b1;
            fault_pc_d_o    = redirect_pc_i;
            fault_cause_d_o = {FAULT_W{1'b1}};
          end else begin
            pc_d_o = redir_tgt;
          end
`else
          pc_d_o = redir_tgt;
`endif
        end else if (fire) begin
          pc_d_o = pc_i + XLEN'(INST_BYTES);
        end
      end
      FAULT: begin
        if (trap_valid_i) begin
`ifdef PC_MISALIGN_CHECK_EN
          if (trap_pc_i[1:0] != 2'b00) begin
            fault_set_o     = 1'b1;
            fault_pc_d_o    = trap_pc_i;
            fault_cause_d_o = {FAULT_W{1'b1}};
          end else begin
            trap_exit_o = 1'b1;
            pc_d_o      = trap_tgt;
          end
`else
          trap_exit_o = 1'b1;
          pc_d_o      = trap_tgt;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: valid/ready request to IFU, EXU redirects, CSR traps,
// and a FAULT state that parks fetch until a trap redirect arrives.
// Optional build macro: PC_MISALIGN_CHECK_EN (misaligned targets fault).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(NPC_RESET_VEC),
  parameter int              INST_BYTES = 4,
  parameter int              FAULT_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    pc,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic [FAULT_W-1:0] access_fault,
  output logic               fault,
  output logic [XLEN-1:0]    fault_pc,
  output logic [FAULT_W-1:0] fault_cause
);

  state_e               state_q;
  logic [XLEN-1:0]      pc_q;
  logic                 out_valid_q;
  logic                 fault_q;
  logic [XLEN-1:0]      fault_pc_q;
  logic [FAULT_W-1:0]   fault_cause_q;

  logic [XLEN-1:0]      pc_d;
  logic                 fault_set;
  logic [XLEN-1:0]      fault_pc_d;
  logic [FAULT_W-1:0]   fault_cause_d;
  logic                 trap_exit;

  pc_next_sel #(
    .XLEN       (XLEN),
    .INST_BYTES (INST_BYTES),
    .FAULT_W    (FAULT_W)
  ) u_next_sel (
    .state_i          (state_q),
    .pc_i             (pc_q),
    .out_valid_i      (out_valid_q),
    .out_ready_i      (out_ready),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .trap_valid_i     (trap_valid),
    .trap_pc_i        (trap_pc),
    .access_fault_i   (access_fault),
    .pc_d_o           (pc_d),
    .fault_set_o      (fault_set),
    .fault_pc_d_o     (fault_pc_d),
    .fault_cause_d_o  (fault_cause_d),
    .trap_exit_o      (trap_exit)
  );

  // Fetch FSM with registered request and fault-record outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VEC;
      out_valid_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_pc_q    <= '0;
      fault_cause_q <= '0;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_q     <= RUN;
          out_valid_q <= 1'b1;
        end
        RUN: begin
          if (fault_set) begin
            state_q       <= FAULT;
            out_valid_q   <= 1'b0;
            fault_q       <= 1'b1;
            fault_pc_q    <= fault_pc_d;
            fault_cause_q <= fault_cause_d;
          end else begin
            pc_q <= pc_d;
          end
        end
        FAULT: begin
          if (fault_set) begin
            fault_pc_q    <= fault_pc_d;
            fault_cause_q <= fault_cause_d;
          end else if (trap_exit) begin
            state_q     <= RUN;
            pc_q        <= pc_d;
            out_valid_q <= 1'b1;
            fault_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= BOOT;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign pc          = pc_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: sequential fetch, stall, redirect/trap
// priority, access-fault entry/exit, wraparound and asynchronous reset.
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [1:0]  access_fault;
  logic        fault;
  logic [31:0] fault_pc;
  logic [1:0]  fault_cause;

  int n_checks = 0;
  int n_errors = 0;

  pc_gen dut (
    .clk            (clk),
    .reset          (reset),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc             (pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .access_fault   (access_fault),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fault_cause    (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pc"},          pc,                 32'h8000_0000);
    chk({tag, ".valid"},       {31'd0, out_valid}, 32'd0);
    chk({tag, ".fault"},       {31'd0, fault},     32'd0);
    chk({tag, ".fault_pc"},    fault_pc,           32'd0);
    chk({tag, ".fault_cause"}, {30'd0, fault_cause}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    trap_valid = 1'b0; trap_pc = '0; access_fault = '0;
    #12;
    chk_reset_vals("reset");

    // Release between edges; BOOT->RUN at the next edge.
    reset = 1'b0;
    tick();
    chk("boot.pc", pc, 32'h8000_0000);
    chk("boot.valid", {31'd0, out_valid}, 32'd1);
    tick(); chk("seq1.pc", pc, 32'h8000_0004);
    tick(); chk("seq2.pc", pc, 32'h8000_0008);

    // Stall: request must hold.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d.pc", i), pc, 32'h8000_0008);
      chk($sformatf("stall%0d.valid", i), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick(); chk("unstall.pc", pc, 32'h8000_000C);

    // Trap beats redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    trap_valid = 1'b1; trap_pc = 32'h8000_0400;
    tick(); chk("trap_vs_redir.pc", pc, 32'h8000_0400);
    trap_valid = 1'b0;

    // Redirect replaces a stalled request.
    out_ready = 1'b0; redirect_pc = 32'h8000_0010;
    tick(); chk("redir_stall.pc", pc, 32'h8000_0010);

    // Access fault overrides a same-cycle redirect.
    redirect_pc = 32'h8000_0300; access_fault = 2'b01;
    tick();
    chk("fault.fault", {31'd0, fault}, 32'd1);
    chk("fault.fault_pc", fault_pc, 32'h8000_0010);
    chk("fault.cause", {30'd0, fault_cause}, 32'd1);
    chk("fault.valid", {31'd0, out_valid}, 32'd0);
    chk("fault.pc", pc, 32'h8000_0010);

    // In FAULT, redirect and new access faults are ignored.
    access_fault = 2'b10;
    tick();
    chk("inflt.pc", pc, 32'h8000_0010);
    chk("inflt.fault", {31'd0, fault}, 32'd1);
    chk("inflt.cause", {30'd0, fault_cause}, 32'd1);
    redirect_valid = 1'b0; access_fault = 2'b00;

    // Trap exits FAULT; fault record is retained.
    trap_valid = 1'b1; trap_pc = 32'h8000_0200;
    tick();
    trap_valid = 1'b0;
    chk("exit.pc", pc, 32'h8000_0200);
    chk("exit.valid", {31'd0, out_valid}, 32'd1);
    chk("exit.fault", {31'd0, fault}, 32'd0);
    chk("exit.fault_pc", fault_pc, 32'h8000_0010);
    chk("exit.cause", {30'd0, fault_cause}, 32'd1);

    // Trap beats a same-cycle access fault.
    trap_valid = 1'b1; trap_pc = 32'h8000_0500; access_fault = 2'b10;
    tick();
    trap_valid = 1'b0; access_fault = 2'b00;
    chk("trap_vs_af.pc", pc, 32'h8000_0500);
    chk("trap_vs_af.fault", {31'd0, fault}, 32'd0);

    // Sequential wraparound.
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); chk("wrap_set.pc", pc, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    tick(); chk("wrap.pc", pc, 32'h0000_0000);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
    chk("misal.fault", {31'd0, fault}, 32'd1);
    chk("misal.cause", {30'd0, fault_cause}, 32'd3);
    chk("misal.fault_pc", fault_pc, 32'h8000_0002);
    chk("misal.valid", {31'd0, out_valid}, 32'd0);
    trap_valid = 1'b1; trap_pc = 32'h8000_0020;
    tick();
    trap_valid = 1'b0;
    chk("misal_exit.pc", pc, 32'h8000_0020);
`else
    chk("misal.pc", pc, 32'h8000_0000);
    chk("misal.fault", {31'd0, fault}, 32'd0);
`endif

    // Enter FAULT, then reset between edges.
    access_fault = 2'b11;
    tick();
    access_fault = 2'b00;
    chk("pre_rst.fault", {31'd0, fault}, 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_fault");
    #1;
    reset = 1'b0;
    tick();
    chk("reboot.valid", {31'd0, out_valid}, 32'd1);

    // Reset during a stalled handshake.
    out_ready = 1'b0;
    tick();
    chk("stall2.valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_stall");
    #1;
    reset = 1'b0;
    tick();
    chk("reboot2.pc", pc, 32'h8000_0000);
    chk("reboot2.valid", {31'd0, out_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
